// File: rtl/out_channel_checker.sv
// out_channel_checker
//   Loads up to DEPTH expected words, then checks the words offered on an
//   output channel against them in order. Reports PASS when every expected
//   word has been matched, FAIL on the first mismatch, on an idle timeout,
//   or on an extra word arriving after PASS (overrun).
//
// Ports
//   clock, reset              : rising-edge clock, synchronous active-high reset
//   load_valid/data/last      : expected-word load channel (input side)
//   load_ready                : high only while loading
//   out_valid/data            : output channel under check
//   out_ready                 : high while running and after pass
//   finished, success         : check complete / every word matched
//   count                     : output words accepted and matched
//   fail_index                : first failing word, DEPTH on timeout/overrun
module out_channel_checker #(
  parameter int WIDTH   = 12,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16,
  localparam int CW     = $clog2(DEPTH + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_last,
  output logic             load_ready,
  input  logic             out_valid,
  input  logic [WIDTH-1:0] out_data,
  output logic             out_ready,
  output logic             finished,
  output logic             success,
  output logic [CW-1:0]    count,
  output logic [CW-1:0]    fail_index
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int IW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {S_LOAD, S_RUN, S_PASS, S_FAIL} state_t;

  state_t           r_state, w_state;
  logic [CW-1:0]    r_n, w_n;
  logic [CW-1:0]    r_count, w_count;
  logic [CW-1:0]    r_fidx, w_fidx;
  logic [IW-1:0]    r_idle, w_idle;
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic r_load_ready, r_out_ready, r_finished, r_success;

  logic w_load_xfer, w_out_xfer;

  // Transfers are qualified by the registered ready, so they only happen in
  // the states that advertise readiness.
  assign w_load_xfer = load_valid && r_load_ready;
  assign w_out_xfer  = out_valid  && r_out_ready;

  always_comb begin
    w_state = r_state;
    w_n     = r_n;
    w_count = r_count;
    w_fidx  = r_fidx;
    w_idle  = r_idle;
    case (r_state)
      S_LOAD: begin
        if (w_load_xfer) begin
          w_n = r_n + CW'(1);
          if (load_last || r_n == CW'(DEPTH - 1)) w_state = S_RUN;
        end
      end
      S_RUN: begin
        if (w_out_xfer) begin
          w_idle = '0;
          if (out_data == r_mem[r_count[AW-1:0]]) begin
            w_count = r_count + CW'(1);
            if (w_count == r_n) w_state = S_PASS;
          end else begin
            w_fidx  = r_count;
            w_state = S_FAIL;
          end
        end else begin
          w_idle = r_idle + IW'(1);
          // The idle count reaching TIMEOUT on this edge ends the check.
          if (r_idle == IW'(TIMEOUT - 1)) begin
            w_fidx  = CW'(DEPTH);
            w_state = S_FAIL;
          end
        end
      end
      S_PASS: begin
        if (w_out_xfer) begin
          w_fidx  = CW'(DEPTH);
          w_state = S_FAIL;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_LOAD;
      r_n          <= '0;
      r_count      <= '0;
      r_fidx       <= '0;
      r_idle       <= '0;
      r_load_ready <= 1'b1;
      r_out_ready  <= 1'b0;
      r_finished   <= 1'b0;
      r_success    <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_n          <= w_n;
      r_count      <= w_count;
      r_fidx       <= w_fidx;
      r_idle       <= w_idle;
      // Handshake/status flags are registered from the next state so they
      // line up with the state change without a decode after the flops.
      r_load_ready <= (w_state == S_LOAD);
      r_out_ready  <= (w_state == S_RUN) || (w_state == S_PASS);
      r_finished   <= (w_state == S_PASS) || (w_state == S_FAIL);
      r_success    <= (w_state == S_PASS);
    end
  end

  // Expected-word storage is not reset; n gates which entries are used.
  always_ff @(posedge clock) begin
    if (!reset && w_load_xfer) r_mem[r_n[AW-1:0]] <= load_data;
  end

  assign load_ready = r_load_ready;
  assign out_ready  = r_out_ready;
  assign finished   = r_finished;
  assign success    = r_success;
  assign count      = r_count;
  assign fail_index = r_fidx;

endmodule
